// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage report scheduler.
//   IDX_W_DEF   : default width of an emitted cover index (longint on the DPI side)
//   state_t     : scheduler FSM states
//   cover_index : absolute cover index from (base, group, bit, group width)
package toggle_cover_pkg;

  localparam int IDX_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Evaluated at full 64-bit width so that base + g*w + b never wraps for any
  // configuration that passes the elaboration range check in the top level.
  function automatic logic [IDX_W_DEF-1:0] cover_index(
    input logic [IDX_W_DEF-1:0] base,
    input int unsigned          g,
    input int unsigned          b,
    input int unsigned          w
  );
    return base + IDX_W_DEF'(g) * IDX_W_DEF'(w) + IDX_W_DEF'(b);
  endfunction

endpackage

// File: rtl/toggle_cover_pick.sv
// Combinational selector: round-robin across NG hit groups starting at 'start'
// (wrapping NG-1 -> 0), then the lowest-numbered pending bit inside the winner.
// Ports:
//   pending     in  NG*W  pending bitmap, group g at [g*W +: W]
//   start       in  GW    first group to consider
//   any_pending out 1     some bit is pending
//   g           out GW    selected group (valid when any_pending)
//   b           out BW    selected bit inside group g
module toggle_cover_pick #(
  parameter  int NG = 4,
  parameter  int W  = 44,
  localparam int GW = (NG > 1) ? $clog2(NG) : 1,
  localparam int BW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [NG*W-1:0] pending,
  input  logic [GW-1:0]   start,
  output logic            any_pending,
  output logic [GW-1:0]   g,
  output logic [BW-1:0]   b
);

  logic [NG-1:0] grp_any;
  logic [BW-1:0] grp_bit [NG];
  logic [GW-1:0] scan_idx;

  function automatic logic [BW-1:0] lowest_bit(input logic [W-1:0] v);
    lowest_bit = '0;
    // Scan downward so the last write wins: that is the lowest set bit.
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = BW'(i);
    end
  endfunction

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    assign grp_any[gi] = |pending[gi*W +: W];
    assign grp_bit[gi] = lowest_bit(pending[gi*W +: W]);
  end

  // Walk offsets from farthest to nearest so the nearest group after 'start'
  // with pending work overwrites all others.
  always_comb begin
    g        = '0;
    scan_idx = '0;
    for (int k = NG - 1; k >= 0; k--) begin
      scan_idx = GW'((int'(start) + k) % NG);
      if (grp_any[scan_idx]) g = scan_idx;
    end
    any_pending = |grp_any;
    b           = grp_bit[g];
  end

endmodule

// File: rtl/toggle_cover_sched.sv
// Toggle-coverage report scheduler. Collects per-cycle hit bits from NG groups
// of W bits into a sticky pending bitmap and streams one absolute cover index
// per cycle to a serial sink over valid/ready. A flush request drains all
// pending bits with capture disabled and then pulses flush_done.
// Optional build macro: TOGGLE_COVER_DEDUP_EN -- keeps a seen bitmap so each
// index is reported at most once between resets.
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-low
//   enable     in   capture enable for hit_valid
//   hit_valid  in   NG*W hit bits, group g at [g*W +: W]
//   out_valid  out  report valid
//   out_ready  in   sink accepts report
//   out_index  out  COVER_BASE + g*W + b
//   flush      in   single-cycle drain request
//   flush_done out  one-cycle pulse when the drain completes
//   busy       out  pending bits exist or FSM not idle
//   merged_cnt out  saturating count of cycles with at least one merged hit
module toggle_cover_sched
  import toggle_cover_pkg::*;
#(
  parameter int              NG         = 4,
  parameter int              W          = 44,
  parameter longint unsigned COVER_BASE = 0,
  parameter int              IDX_W      = IDX_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [NG*W-1:0]  hit_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy,
  output logic [31:0]      merged_cnt
);

  localparam int NB = NG * W;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [127:0] INDEX_END   = 128'(COVER_BASE) + 128'(NG) * 128'(W);
  localparam logic [127:0] INDEX_LIMIT = 128'(1) << IDX_W;

  if (IDX_W > IDX_W_DEF || INDEX_END > INDEX_LIMIT) begin : g_range_err
    $error("toggle_cover_sched: COVER_BASE + NG*W does not fit in IDX_W bits");
  end

  state_t           state_reg, state_next;
  logic [NB-1:0]    pending_reg, pending_next;
  logic [GW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic             out_valid_reg, out_valid_next;
  logic [IDX_W-1:0] out_index_reg, out_index_next;
  logic [GW-1:0]    out_g_reg, out_g_next;
  logic [PW-1:0]    out_pos_reg, out_pos_next;
  logic             flush_latched_reg, flush_latched_next;
  logic             flush_done_reg;
  logic [31:0]      merged_cnt_reg, merged_cnt_next;

  logic             hs;
  logic [NB-1:0]    clear_mask;
  logic [NB-1:0]    pending_clr;
  logic [NB-1:0]    hit_eff;
  logic             capture_en;
  logic             merge_any;
  logic             load_sel;
  logic             pick_any;
  logic [GW-1:0]    pick_g;
  logic [BW-1:0]    pick_b;

  assign hs = out_valid_reg && out_ready;

  for (genvar gi = 0; gi < NB; gi++) begin : g_clr
    assign clear_mask[gi] = hs && (out_pos_reg == PW'(gi));
  end

  assign pending_clr = pending_reg & ~clear_mask;

  // After a handshake the scan restarts just past the group that was served.
  assign rr_ptr_next = !hs ? rr_ptr_reg :
                       (out_g_reg == GW'(NG - 1)) ? '0 : out_g_reg + 1'b1;

`ifdef TOGGLE_COVER_DEDUP_EN
  logic [NB-1:0] seen_reg;

  always_ff @(posedge clock) begin
    if (!reset) seen_reg <= '0;
    else        seen_reg <= seen_reg | clear_mask;
  end

  // The bit being handshaken this cycle is treated as already seen.
  assign hit_eff = hit_valid & ~(seen_reg | clear_mask);
`else
  assign hit_eff = hit_valid;
`endif

  assign capture_en   = enable && (state_reg == IDLE || state_reg == EMIT);
  // OR-ing hits after the clear lets a same-cycle re-hit survive its handshake.
  assign pending_next = capture_en ? (pending_clr | hit_eff) : pending_clr;
  assign merge_any    = capture_en && |(hit_eff & pending_clr);

  always_comb begin
    merged_cnt_next = merged_cnt_reg;
    if (merge_any && merged_cnt_reg != 32'hFFFF_FFFF) merged_cnt_next = merged_cnt_reg + 32'd1;
  end

  toggle_cover_pick #(.NG(NG), .W(W)) u_pick (
    .pending     (pending_clr),
    .start       (rr_ptr_next),
    .any_pending (pick_any),
    .g           (pick_g),
    .b           (pick_b)
  );

  always_comb begin
    state_next         = state_reg;
    out_valid_next     = out_valid_reg;
    out_index_next     = out_index_reg;
    out_g_next         = out_g_reg;
    out_pos_next       = out_pos_reg;
    flush_latched_next = flush_latched_reg;
    load_sel           = 1'b0;
    case (state_reg)
      IDLE: begin
        load_sel = pick_any;
        if (flush)         state_next = pick_any ? DRAIN : DONE;
        else if (pick_any) state_next = EMIT;
      end
      EMIT: begin
        if (flush) flush_latched_next = 1'b1;
        if (hs) begin
          load_sel = pick_any;
          if (flush || flush_latched_reg) begin
            state_next         = DRAIN;
            flush_latched_next = 1'b0;
          end else if (!pick_any) begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        // out_valid can be low here when EMIT ran dry on the handshake that
        // started the drain but captured new hits in that same cycle.
        if (hs || !out_valid_reg) begin
          load_sel = pick_any;
          if (!pick_any) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (load_sel) begin
      out_valid_next = 1'b1;
      out_index_next = IDX_W'(cover_index(COVER_BASE, 32'(pick_g), 32'(pick_b), W));
      out_g_next     = pick_g;
      out_pos_next   = PW'(32'(pick_g) * W + 32'(pick_b));
    end else if (hs) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg         <= IDLE;
      pending_reg       <= '0;
      rr_ptr_reg        <= '0;
      out_valid_reg     <= 1'b0;
      out_index_reg     <= '0;
      out_g_reg         <= '0;
      out_pos_reg       <= '0;
      flush_latched_reg <= 1'b0;
      flush_done_reg    <= 1'b0;
      merged_cnt_reg    <= '0;
    end else begin
      state_reg         <= state_next;
      pending_reg       <= pending_next;
      rr_ptr_reg        <= rr_ptr_next;
      out_valid_reg     <= out_valid_next;
      out_index_reg     <= out_index_next;
      out_g_reg         <= out_g_next;
      out_pos_reg       <= out_pos_next;
      flush_latched_reg <= flush_latched_next;
      flush_done_reg    <= (state_next == DONE);
      merged_cnt_reg    <= merged_cnt_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_index  = out_index_reg;
  assign flush_done = flush_done_reg;
  assign merged_cnt = merged_cnt_reg;
  assign busy       = (|pending_reg) || (state_reg != IDLE);

endmodule
